// File: rtl/mem_rw_bank_merge.sv
// Merges a read-side and a write-side memory request port onto one
// single-ported SRAM bank. Round-robin arbitration picks the port. A small
// FIFO remembers which port each grant went to, so the bank's in-order
// responses can be steered back to the right port.
module mem_rw_bank_merge #(
  parameter int unsigned AddrWidth      = 32,
  parameter int unsigned DataWidth      = 32,
  parameter int unsigned MaxOutstanding = 2
) (
  input  logic                             clk_i,
  input  logic                             rst_i,
  input  logic [1:0]                       p_req_i,
  output logic [1:0]                       p_gnt_o,
  input  logic [1:0][AddrWidth-1:0]        p_addr_i,
  input  logic [1:0][DataWidth-1:0]        p_wdata_i,
  input  logic [1:0][DataWidth/8-1:0]      p_strb_i,
  input  logic [1:0][5:0]                  p_atop_i,
  input  logic [1:0]                       p_we_i,
  output logic [1:0]                       p_rvalid_o,
  output logic [1:0][DataWidth-1:0]        p_rdata_o,
  output logic                             bank_req_o,
  input  logic                             bank_gnt_i,
  output logic [AddrWidth-1:0]             bank_addr_o,
  output logic [DataWidth-1:0]             bank_wdata_o,
  output logic [DataWidth/8-1:0]           bank_strb_o,
  output logic [5:0]                       bank_atop_o,
  output logic                             bank_we_o,
  input  logic                             bank_rvalid_i,
  input  logic [DataWidth-1:0]             bank_rdata_i,
  output logic                             err_o
);

  localparam int unsigned PtrWidth = (MaxOutstanding > 1) ? $clog2(MaxOutstanding) : 1;
  localparam int unsigned CntWidth = $clog2(MaxOutstanding + 1);

  // Pointers wrap at MaxOutstanding, which need not be a power of two.
  function automatic logic [PtrWidth-1:0] ptr_inc(input logic [PtrWidth-1:0] p);
    if (p == PtrWidth'(MaxOutstanding - 1)) return '0;
    return p + PtrWidth'(1);
  endfunction

  logic                      rr_q, rr_d;
  logic [PtrWidth-1:0]       wptr_q, wptr_d;
  logic [PtrWidth-1:0]       rptr_q, rptr_d;
  logic [CntWidth-1:0]       cnt_q, cnt_d;
  logic                      err_q, err_d;
  logic [MaxOutstanding-1:0] port_q;

  logic any_req;
  logic sel;
  logic full;
  logic empty;
  logic push;
  logic pop;
  logic head;

  // Arbitration, FIFO status and handshake decode.
  always_comb begin
    any_req = |p_req_i;
    if (p_req_i == 2'b11) sel = rr_q;
    else                  sel = p_req_i[1];
    full  = (cnt_q == CntWidth'(MaxOutstanding));
    empty = (cnt_q == '0);
    push  = any_req & ~full & bank_gnt_i;
    pop   = bank_rvalid_i & ~empty;
    head  = port_q[rptr_q];
  end

  // Next-state for the RR pointer, FIFO pointers/count and sticky error.
  always_comb begin
    rr_d   = rr_q;
    wptr_d = wptr_q;
    rptr_d = rptr_q;
    cnt_d  = cnt_q;
    err_d  = err_q;
    if (push) begin
      rr_d   = ~sel;
      wptr_d = ptr_inc(wptr_q);
    end
    if (pop) rptr_d = ptr_inc(rptr_q);
    case ({push, pop})
      2'b10:   cnt_d = cnt_q + CntWidth'(1);
      2'b01:   cnt_d = cnt_q - CntWidth'(1);
      default: cnt_d = cnt_q;
    endcase
    // A response with nothing outstanding (judged on registered state) is spurious.
    if (bank_rvalid_i && empty) err_d = 1'b1;
  end

  // Control state register.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      rr_q   <= 1'b0;
      wptr_q <= '0;
      rptr_q <= '0;
      cnt_q  <= '0;
      err_q  <= 1'b0;
    end else begin
      rr_q   <= rr_d;
      wptr_q <= wptr_d;
      rptr_q <= rptr_d;
      cnt_q  <= cnt_d;
      err_q  <= err_d;
    end
  end

  // Grant-tracking storage; contents are only meaningful below the count.
  always_ff @(posedge clk_i) begin
    if (push) port_q[wptr_q] <= sel;
  end

  // Bank-side request mux and port-side grant/response steering.
  always_comb begin
    bank_req_o   = any_req & ~full;
    bank_addr_o  = '0;
    bank_wdata_o = '0;
    bank_strb_o  = '0;
    bank_atop_o  = '0;
    bank_we_o    = 1'b0;
    if (any_req) begin
      bank_addr_o  = p_addr_i[sel];
      bank_wdata_o = p_wdata_i[sel];
      bank_strb_o  = p_strb_i[sel];
      bank_atop_o  = p_atop_i[sel];
      bank_we_o    = p_we_i[sel];
    end
    p_gnt_o         = 2'b00;
    p_gnt_o[sel]    = push;
    p_rvalid_o      = 2'b00;
    p_rvalid_o[head] = pop;
    p_rdata_o[0]    = bank_rdata_i;
    p_rdata_o[1]    = bank_rdata_i;
    err_o           = err_q;
  end

endmodule

// File: tb/tb_mem_rw_bank_merge.sv
// Bench for mem_rw_bank_merge: directed scenarios followed by random traffic,
// all checked against a queue-based reference model of outstanding grants.
module tb_mem_rw_bank_merge;

  localparam int AW = 32;
  localparam int DW = 32;
  localparam int SW = DW / 8;
  localparam int MO = 2;

  logic                 clk = 1'b0;
  logic                 rst;
  logic [1:0]           p_req;
  logic [1:0]           p_gnt;
  logic [1:0][AW-1:0]   p_addr;
  logic [1:0][DW-1:0]   p_wdata;
  logic [1:0][SW-1:0]   p_strb;
  logic [1:0][5:0]      p_atop;
  logic [1:0]           p_we;
  logic [1:0]           p_rvalid;
  logic [1:0][DW-1:0]   p_rdata;
  logic                 bank_req;
  logic                 bank_gnt;
  logic [AW-1:0]        bank_addr;
  logic [DW-1:0]        bank_wdata;
  logic [SW-1:0]        bank_strb;
  logic [5:0]           bank_atop;
  logic                 bank_we;
  logic                 bank_rvalid;
  logic [DW-1:0]        bank_rdata;
  logic                 err;

  always #5 clk = ~clk;

  mem_rw_bank_merge #(
    .AddrWidth(AW), .DataWidth(DW), .MaxOutstanding(MO)
  ) dut (
    .clk_i(clk), .rst_i(rst),
    .p_req_i(p_req), .p_gnt_o(p_gnt), .p_addr_i(p_addr), .p_wdata_i(p_wdata),
    .p_strb_i(p_strb), .p_atop_i(p_atop), .p_we_i(p_we),
    .p_rvalid_o(p_rvalid), .p_rdata_o(p_rdata),
    .bank_req_o(bank_req), .bank_gnt_i(bank_gnt), .bank_addr_o(bank_addr),
    .bank_wdata_o(bank_wdata), .bank_strb_o(bank_strb), .bank_atop_o(bank_atop),
    .bank_we_o(bank_we), .bank_rvalid_i(bank_rvalid), .bank_rdata_i(bank_rdata),
    .err_o(err)
  );

  int checks = 0;
  int errors = 0;

  // Reference model: ports of granted-but-unanswered requests, oldest first.
  int   mq[$];
  int   rr_m;
  bit   err_m;
  bit   hs_prev;
  logic [1:0] last_gnt;
  logic [1:0] last_rv;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    mq.delete();
    rr_m    = 0;
    err_m   = 1'b0;
    hs_prev = 1'b0;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    p_req = '0; p_we = '0; p_addr = '0; p_wdata = '0; p_strb = '0; p_atop = '0;
    bank_gnt = 1'b0; bank_rvalid = 1'b0; bank_rdata = '0;
    #1;
    chk("rst_bank_req", 64'(bank_req), 64'd0);
    chk("rst_gnt", 64'(p_gnt), 64'd0);
    chk("rst_rvalid", 64'(p_rvalid), 64'd0);
    chk("rst_err", 64'(err), 64'd0);
    chk("rst_addr", 64'(bank_addr), 64'd0);
    @(posedge clk); #1;
    rst = 1'b0;
    model_reset();
  endtask

  // One clock cycle: drive, check at the falling edge, advance the model.
  task automatic step(input logic [1:0] req, input logic [1:0] we, input logic g, input logic rv);
    bit   any, full, bq, was_empty;
    int   sel;
    logic [1:0] eg, erv;
    p_req = req;
    p_we  = we;
    for (int i = 0; i < 2; i++) begin
      p_addr[i]  = $urandom;
      p_wdata[i] = $urandom;
      p_strb[i]  = SW'($urandom);
      p_atop[i]  = 6'($urandom);
    end
    bank_gnt    = g;
    bank_rvalid = rv;
    bank_rdata  = $urandom;
    @(negedge clk);
    any       = |req;
    full      = (mq.size() == MO);
    was_empty = (mq.size() == 0);
    sel       = (req == 2'b11) ? rr_m : (req[1] ? 1 : 0);
    bq        = any && !full;
    eg        = (g && bq) ? 2'(1 << sel) : 2'b00;
    erv       = (rv && !was_empty) ? 2'(1 << mq[0]) : 2'b00;
    chk("bank_req", 64'(bank_req), 64'(bq));
    chk("p_gnt", 64'(p_gnt), 64'(eg));
    chk("bank_addr", 64'(bank_addr), any ? 64'(p_addr[sel]) : 64'd0);
    chk("bank_wdata", 64'(bank_wdata), any ? 64'(p_wdata[sel]) : 64'd0);
    chk("bank_strb", 64'(bank_strb), any ? 64'(p_strb[sel]) : 64'd0);
    chk("bank_atop", 64'(bank_atop), any ? 64'(p_atop[sel]) : 64'd0);
    chk("bank_we", 64'(bank_we), any ? 64'(we[sel]) : 64'd0);
    chk("p_rvalid", 64'(p_rvalid), 64'(erv));
    chk("p_rdata0", 64'(p_rdata[0]), 64'(bank_rdata));
    chk("p_rdata1", 64'(p_rdata[1]), 64'(bank_rdata));
    chk("err", 64'(err), 64'(err_m));
    last_gnt = p_gnt;
    last_rv  = p_rvalid;
    if (erv != 2'b00) void'(mq.pop_front());
    if (rv && was_empty) err_m = 1'b1;
    hs_prev = g && bq;
    if (hs_prev) begin
      mq.push_back(sel);
      rr_m = 1 - sel;
    end
    @(posedge clk); #1;
  endtask

  initial begin
    int ng;
    logic [1:0] exp_seq [4];
    logic [1:0] rq;
    logic       rvr;
    rst = 1'b1;
    model_reset();
    @(posedge clk); #1;

    // Read port alone, latency-1 bank.
    do_reset();
    for (int k = 0; k < 4; k++) begin
      step(2'b01, 2'b00, 1'b1, hs_prev);
      chk("t1_gnt", 64'(last_gnt), 64'd1);
      if (k > 0) chk("t1_rv", 64'(last_rv), 64'd1);
    end
    step(2'b00, 2'b00, 1'b0, hs_prev);
    chk("t1_rv_last", 64'(last_rv), 64'd1);
    chk("t1_err", 64'(err), 64'd0);

    // Both ports: alternate grants, responses follow grant order.
    do_reset();
    exp_seq[0] = 2'b01; exp_seq[1] = 2'b10; exp_seq[2] = 2'b01; exp_seq[3] = 2'b10;
    for (int k = 0; k < 4; k++) begin
      step(2'b11, 2'b10, 1'b1, hs_prev);
      chk("t2_gnt", 64'(last_gnt), 64'(exp_seq[k]));
      if (k > 0) chk("t2_rv", 64'(last_rv), 64'(exp_seq[k-1]));
    end
    step(2'b00, 2'b00, 1'b0, hs_prev);
    chk("t2_rv_last", 64'(last_rv), 64'd2);

    // Back-pressure at MaxOutstanding, then one response frees one slot.
    do_reset();
    ng = 0;
    for (int k = 0; k < 4; k++) begin
      step(2'b11, 2'b00, 1'b1, 1'b0);
      if (last_gnt != 2'b00) ng++;
    end
    chk("t3_ngrants", 64'(ng), 64'd2);
    step(2'b11, 2'b00, 1'b1, 1'b1);
    chk("t3_gnt_on_pop", 64'(last_gnt), 64'd0);
    chk("t3_rv", 64'(last_rv), 64'd1);
    step(2'b11, 2'b00, 1'b1, 1'b0);
    chk("t3_gnt_after", 64'(last_gnt), 64'd1);
    step(2'b00, 2'b00, 1'b0, 1'b1);
    step(2'b00, 2'b00, 1'b0, 1'b1);

    // Bank stalls: no grants, RR preference holds.
    do_reset();
    for (int k = 0; k < 3; k++) begin
      step(2'b11, 2'b01, 1'b0, 1'b0);
      chk("t4_gnt", 64'(last_gnt), 64'd0);
    end

    // Spurious response right after reset.
    do_reset();
    step(2'b00, 2'b00, 1'b0, 1'b1);
    chk("t5_rv", 64'(last_rv), 64'd0);
    for (int k = 0; k < 3; k++) begin
      step(2'b00, 2'b00, 1'b0, 1'b0);
      chk("t5_err_sticky", 64'(err), 64'd1);
    end

    // Reset with two outstanding; stale responses flag err, new read routes.
    do_reset();
    step(2'b01, 2'b00, 1'b1, 1'b0);
    step(2'b01, 2'b00, 1'b1, 1'b0);
    do_reset();
    step(2'b00, 2'b00, 1'b0, 1'b1);
    step(2'b00, 2'b00, 1'b0, 1'b1);
    step(2'b01, 2'b00, 1'b1, 1'b0);
    chk("t6_gnt", 64'(last_gnt), 64'd1);
    step(2'b00, 2'b00, 1'b0, 1'b1);
    chk("t6_rv", 64'(last_rv), 64'd1);
    chk("t6_err", 64'(err), 64'd1);

    // Random traffic.
    do_reset();
    for (int k = 0; k < 400; k++) begin
      rq  = 2'($urandom);
      rvr = (mq.size() > 0) ? 1'($urandom % 2) : (($urandom % 16) == 0);
      step(rq, 2'($urandom), (($urandom % 4) != 0), rvr);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
